instr_prefetch: RTL
===================

INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, number of prefetch-buffer entries and maximum outstanding memory requests; power of two, at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, asynchronous reset, active-low (asserted when 0).
REQ-005 Port imem_req_valid, output, 1, fetch request valid.
REQ-006 Port imem_req_ready, input, 1, instruction memory accepts the request.
REQ-007 Port imem_req_addr, output, 32, word-aligned fetch address.
REQ-008 Port imem_rsp_valid, input, 1, one in-order response word this cycle; no back-pressure.
REQ-009 Port imem_rsp_data, input, 32, response instruction word.
REQ-010 Port out_valid, output, 1, buffered instruction available to IF/ID.
REQ-011 Port out_ready, input, 1, pipeline accepts the instruction (driven low while the pipeline stalls).
REQ-012 Port out_pc, output, 32, PC of the head instruction.
REQ-013 Port out_instr, output, 32, head instruction word.
REQ-014 Port redirect, input, 1, EX-stage taken branch/jump; flush and refetch.
REQ-015 Port redirect_pc, input, 32, new fetch target; bits [1:0] ignored and treated as 0.

Function
REQ-016 The request handshake SHALL complete when imem_req_valid and imem_req_ready are both 1 at a rising edge; fetch_pc then advances by 4 (32-bit wrap at 32'hFFFF_FFFC to 0).
REQ-017 imem_req_valid SHALL be 1 only when (buffer occupancy + outstanding requests) < DEPTH and redirect is 0 and the block is not in reset.
REQ-018 imem_req_addr SHALL equal fetch_pc and SHALL stay stable while imem_req_valid=1 and imem_req_ready=0.
REQ-019 Outstanding count SHALL increment on an accepted request, decrement on each imem_rsp_valid, and both in one cycle SHALL leave it unchanged.
REQ-020 Each non-discarded response SHALL be written to the buffer tail as {rsp_pc, imem_rsp_data}; rsp_pc then advances by 4.
REQ-021 out_valid SHALL equal buffer-not-empty; out_pc/out_instr SHALL show the head entry, registered, no combinational path from imem_rsp_* to out_*.
REQ-022 The head SHALL be popped when out_valid and out_ready are both 1; simultaneous push and pop at any occupancy, including full and empty, SHALL be legal and preserve order.
REQ-023 The credit rule in REQ-017 SHALL guarantee no push into a full buffer; a response arriving when full is a protocol violation flagged by a simulation-only assertion.
REQ-024 Redirect SHALL take effect at the rising edge where redirect=1: buffer emptied, fetch_pc and rsp_pc set to {redirect_pc[31:2],2'b00}, drop count set to outstanding count after that cycle's updates, no request issued that cycle.
REQ-025 While drop count > 0, each imem_rsp_valid SHALL decrement drop count and outstanding count and SHALL NOT be written to the buffer.
REQ-026 A response or pop in the same cycle as redirect SHALL be discarded; redirect has priority over every other event.
REQ-027 Back-to-back redirects SHALL each apply; the last one sets the target and drop count accumulates all in-flight requests.
REQ-028 Minimum latency: redirect at edge N gives imem_req_valid at cycle N+1, and a zero-latency memory response gives out_valid one cycle after the response edge.

Reset
REQ-029 While rst=0 the block SHALL asynchronously clear buffer, outstanding count, and drop count, and SHALL set fetch_pc=rsp_pc=RESET_PC.
REQ-030 During and right after reset, imem_req_valid=0, out_valid=0, out_pc=0, out_instr=0 (NOP not required).
REQ-031 Reset asserted mid-transaction SHALL abandon all in-flight requests; the memory model is reset together with the block.

Verification
REQ-032 Release reset, imem_req_ready=1, 1-cycle memory, out_ready=1 -> requests 0x0,0x4,0x8...; out_pc sequence 0x0,0x4,0x8 with matching words, one per cycle in steady state.
REQ-033 out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, buffer full, imem_req_valid=0; out_ready=1 then drains 0x0..0xC in order and fetching resumes at 0x10.
REQ-034 Three requests outstanding, redirect to 0x100 -> three responses dropped, next out_pc=0x100, no stale instruction ever has out_valid=1.
REQ-035 redirect_pc=0x203 -> imem_req_addr=0x200 and out_pc=0x200.
REQ-036 Redirect in the same cycle as a response and a pop -> response discarded, buffer empty next cycle, drop count equals remaining outstanding.
REQ-037 Assert rst=0 asynchronously mid-burst -> outputs clear without a clock edge; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_prefetch.sv
// Instruction prefetch buffer: credit-limited in-order fetch into a small FIFO,
// with redirect flushing the buffer and discarding responses still in flight.
module instr_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);

    logic [31:0]   pc_buf    [DEPTH];
    logic [31:0]   instr_buf [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count, outstanding, drop;
    logic [31:0]   fetch_pc, rsp_pc;
    logic          active;

    logic [CW:0]   in_use;
    logic [CW-1:0] rsp_dec;
    logic [31:0]   target;
    logic          req_fire, dropping, push, pop;

    // Credits cover both buffered entries and requests still in flight,
    // so a response always finds a free slot.
    assign in_use         = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = active && !redirect && (in_use < DEPTH_L);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_dec        = CW'(imem_rsp_valid);
    assign target         = redirect_pc & 32'hFFFF_FFFC;
    assign dropping       = (drop != '0);
    assign push           = imem_rsp_valid && !redirect && !dropping;
    assign out_valid      = (count != '0);
    assign pop            = out_valid && out_ready && !redirect;
    assign out_pc         = out_valid ? pc_buf[head]    : 32'h0;
    assign out_instr      = out_valid ? instr_buf[head] : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            active      <= 1'b0;
        end else begin
            active <= 1'b1;
            if (redirect) begin
                // Everything still in flight after this edge is stale.
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                fetch_pc    <= target;
                rsp_pc      <= target;
                outstanding <= outstanding - rsp_dec;
                drop        <= outstanding - rsp_dec;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                case ({req_fire, imem_rsp_valid})
                    2'b10:   outstanding <= outstanding + 1'b1;
                    2'b01:   outstanding <= outstanding - 1'b1;
                    default: ;
                endcase
                if (imem_rsp_valid && dropping)
                    drop <= drop - 1'b1;
                if (push) begin
                    tail   <= tail + 1'b1;
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (pop)
                    head <= head + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_buf[tail]    <= rsp_pc;
            instr_buf[tail] <= imem_rsp_data;
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
        !(push && (count == DEPTH_C) && !pop));

endmodule
